avmm_ccip_burst_splitter: RTL and testbench
===========================================

// Module: avmm_ccip_burst_splitter
// PURPOSE
//  Sits directly upstream of the CCI-P host bridge on the Avalon-MM host path. Accepts Avalon
//  read/write bursts of 1..MAX_BURST lines and issues only CCI-P-legal sub-bursts downstream:
//  length 1, 2 or 4 lines, naturally aligned, never crossing a 4-line boundary.
//  Holds the address and burstcount stable for every beat of a sub-burst.
//  Forwards the write-fence bit (address[48]) on the first write sub-burst only.
// PARAMETERS
//  ADDR_WIDTH   49   byte address; bit 48 = write-fence flag, [47:6] = line address
//  DATA_WIDTH   512  data width = CCIP_AVMM_REQUESTOR_DATA_WIDTH
//  BURST_WIDTH  7    upstream burstcount width; MAX_BURST = 2**(BURST_WIDTH-1) = 64 lines
//  MAX_PEND_RD  256  outstanding read-line limit; used only with the macro below
// PORTS
//  clk                 in   1            clock
//  reset               in   1            synchronous, active-high
//  s_address           in   ADDR_WIDTH   upstream address; bits [5:0] ignored
//  s_burstcount        in   BURST_WIDTH  upstream burst length in lines; 0 illegal
//  s_read / s_write    in   1            upstream commands; mutually exclusive
//  s_writedata         in   DATA_WIDTH   write beat data
//  s_byteenable        in   DATA_WIDTH/8 passed through unchanged
//  s_waitrequest       out  1            upstream backpressure
//  s_readdata          out  DATA_WIDTH   = m_readdata (combinational)
//  s_readdatavalid     out  1            = m_readdatavalid (combinational)
//  m_address           out  ADDR_WIDTH   sub-burst start address, [5:0] = 0
//  m_burstcount        out  3            1, 2 or 4 (CCIP_AVMM_REQUESTOR_BURST_WIDTH)
//  m_read / m_write    out  1            downstream commands
//  m_writedata / m_byteenable  out       = s_writedata / s_byteenable
//  m_waitrequest       in   1            downstream backpressure
//  m_readdata / m_readdatavalid  in      downstream read response, in order
// BEHAVIOUR
//  split(line, rem): 4 if line[1:0]==0 && rem>=4; else 2 if line[0]==0 && rem>=2; else 1.
//  State: IDLE, RD_SPLIT, WR_BURST. Registers: cur_line[41:0], rem_total[BURST_WIDTH-1:0],
//  sub_left[2:0], first_sub. Accept = m_read|m_write && !m_waitrequest.
//  IDLE + s_read:
//   - m_read=1, m_address={s_address[48:6],6'b0}, m_burstcount=split(s line, s_burstcount).
//   - If len == s_burstcount: s_waitrequest = m_waitrequest; stay in IDLE.
//   - Else: s_waitrequest=1. On accept, load cur_line+=len and rem_total-=len; go to RD_SPLIT.
//  RD_SPLIT:
//   - Upstream holds its command stable. m_read=1; m_address uses cur_line;
//     m_burstcount=split(cur_line, rem_total).
//   - s_waitrequest=0 only in the cycle the final sub-burst is accepted; then go to IDLE.
//   - Zero added command latency. Read data is passed through with no added latency.
//  IDLE + s_write (first beat):
//   - m_write=1; m_address=s_address with bit48 as given; m_burstcount=split.
//   - s_waitrequest = m_waitrequest.
//   - On accept: if s_burstcount==1, stay in IDLE. Else latch sub-burst start, sub_left=len-1,
//     rem_total=s_burstcount-1, first_sub=1, and go to WR_BURST.
//  WR_BURST:
//   - m_address and m_burstcount are held from the latched sub-burst start.
//   - Each accepted beat decrements sub_left and rem_total.
//   - When sub_left reaches 0 with rem_total>0: the next beat starts a new sub-burst at
//     cur_line with split(cur_line, rem_total), and first_sub clears.
//   - m_address[48] = s_address[48] & first_sub: exactly one fence per original burst.
//   - rem_total==0 after an accept: go to IDLE.
//  Upstream s_address/s_burstcount are ignored on non-first write beats.
//  m_waitrequest high: nothing advances, and all m_* outputs hold.
//  Reset, including mid-burst: state=IDLE, all counters 0, pending=0.
//   - m_read=m_write=0 while reset is high; s_waitrequest=1 while reset is high.
//   - A partially issued burst is abandoned.
// CONFIGURATION
//  CCIP_AVMM_SPLITTER_RD_THROTTLE_EN defined:
//   - pending counter (width clog2(MAX_PEND_RD)+1): +len on read accept, -1 per m_readdatavalid.
//   - Same-cycle accept and readdatavalid: net change = len-1.
//   - m_read is gated low (s_waitrequest=1) while pending+len > MAX_PEND_RD.
//  Macro not defined: no counter and no read gating.
// STRUCTURE
//  ccip_avmm_pkg additions:
//   - function ccip_avmm_split_len(line[1:0], rem) returning 1/2/4
//   - typedef t_split_state {IDLE, RD_SPLIT, WR_BURST}
//   - localparam CCIP_AVMM_FENCE_BIT = 48
//  One sub-module: avmm_ccip_rd_pending_cnt, the throttle counter, instantiated only under the macro.
// TESTING
//  1. Write burst 7 at line 1 -> sub-bursts 1@line1, 2@line2, 4@line4; 7 beats forwarded in order.
//  2. Read burst 64 at line 0 -> 16 reads of 4 at lines 0,4,..,60; s_waitrequest low only on the 16th.
//  3. Write burst 4, addr bit48=1, line 2 -> 2@line2 with bit48=1, then 2@line4 with bit48=0.
//  4. m_waitrequest high for 3 cycles on beat 3 of burst 4 -> m_address/m_burstcount/m_writedata held; beat count unchanged.
//  5. Macro on, MAX_PEND_RD=8: two 4-line reads accepted; third is stalled until the first readdatavalid.
//  6. Reset asserted on beat 2 of a 4-beat write -> m_write=0 on the next cycle, state IDLE; a new burst works normally.

Source files
------------

// File: rtl/ccip_avmm_pkg.sv
// rtl/ccip_avmm_pkg.sv - shared types, constants and sub-burst length helper for the CCI-P AVMM path
package ccip_avmm_pkg;

    localparam int CCIP_AVMM_FENCE_BIT = 48;
    localparam int CCIP_AVMM_LINE_LSB  = 6;
    localparam int CCIP_AVMM_LINE_W    = CCIP_AVMM_FENCE_BIT - CCIP_AVMM_LINE_LSB;

    typedef enum logic [1:0] {
        IDLE,
        RD_SPLIT,
        WR_BURST
    } t_split_state;

    // Largest naturally aligned CCI-P length (4, 2 or 1) that fits in the remaining lines.
    function automatic logic [2:0] ccip_avmm_split_len(input logic [1:0] line, input logic [15:0] rem);
        if (line == 2'b00 && rem >= 16'd4) begin
            return 3'd4;
        end else if (!line[0] && rem >= 16'd2) begin
            return 3'd2;
        end else begin
            return 3'd1;
        end
    endfunction

endpackage

// File: rtl/avmm_ccip_rd_pending_cnt.sv
// rtl/avmm_ccip_rd_pending_cnt.sv - outstanding read-line counter that stalls reads above MAX_PEND_RD
module avmm_ccip_rd_pending_cnt #(
    parameter int MAX_PEND_RD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_accept,
    input  logic [2:0] rd_len,
    input  logic       rsp_valid,
    output logic       block
);

    localparam int PW = $clog2(MAX_PEND_RD) + 1;

    logic [PW-1:0] pending;
    logic [PW-1:0] add_len;
    logic [PW-1:0] sub_one;

    assign add_len = rd_accept ? PW'(rd_len) : '0;
    assign sub_one = rsp_valid ? PW'(1) : '0;

    // Same-cycle accept and response nets to len-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending + add_len - sub_one;
        end
    end

    assign block = ({1'b0, pending} + (PW + 1)'(rd_len)) > (PW + 1)'(MAX_PEND_RD);

endmodule

// File: rtl/avmm_ccip_burst_splitter.sv
// rtl/avmm_ccip_burst_splitter.sv - splits Avalon-MM bursts into aligned 1/2/4-line CCI-P sub-bursts
// Optional read throttle: CCIP_AVMM_SPLITTER_RD_THROTTLE_EN
module avmm_ccip_burst_splitter
    import ccip_avmm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 49,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7,
    parameter int MAX_PEND_RD = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_address,
    input  logic [BURST_WIDTH-1:0]  s_burstcount,
    input  logic                    s_read,
    input  logic                    s_write,
    input  logic [DATA_WIDTH-1:0]   s_writedata,
    input  logic [DATA_WIDTH/8-1:0] s_byteenable,
    output logic                    s_waitrequest,
    output logic [DATA_WIDTH-1:0]   s_readdata,
    output logic                    s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic [2:0]              m_burstcount,
    output logic                    m_read,
    output logic                    m_write,
    output logic [DATA_WIDTH-1:0]   m_writedata,
    output logic [DATA_WIDTH/8-1:0] m_byteenable,
    input  logic                    m_waitrequest,
    input  logic [DATA_WIDTH-1:0]   m_readdata,
    input  logic                    m_readdatavalid
);

    localparam int LW = CCIP_AVMM_LINE_W;

    t_split_state           state;
    logic [LW-1:0]          cur_line;
    logic [LW-1:0]          sub_line;
    logic [BURST_WIDTH-1:0] rem_total;
    logic [2:0]             sub_left;
    logic [2:0]             sub_len;
    logic                   first_sub;
    logic                   fence_q;

    logic [LW-1:0]          s_line;
    logic [2:0]             s_len;
    logic [2:0]             c_len;
    logic                   rd_block;
    logic                   accept;
    logic                   unused_addr_lsb;

    assign s_line          = s_address[CCIP_AVMM_FENCE_BIT-1:CCIP_AVMM_LINE_LSB];
    assign s_len           = ccip_avmm_split_len(s_line[1:0], 16'(s_burstcount));
    assign c_len           = ccip_avmm_split_len(cur_line[1:0], 16'(rem_total));
    assign accept          = (m_read | m_write) & ~m_waitrequest;
    assign unused_addr_lsb = ^s_address[CCIP_AVMM_LINE_LSB-1:0];

    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign s_readdata      = m_readdata;
    assign s_readdatavalid = m_readdatavalid;

`ifdef CCIP_AVMM_SPLITTER_RD_THROTTLE_EN
    logic [2:0] rd_len;

    assign rd_len = (state == RD_SPLIT) ? c_len : s_len;

    avmm_ccip_rd_pending_cnt #(
        .MAX_PEND_RD (MAX_PEND_RD)
    ) u_rd_pending_cnt (
        .clk       (clk),
        .reset     (reset),
        .rd_accept (m_read & ~m_waitrequest),
        .rd_len    (rd_len),
        .rsp_valid (m_readdatavalid),
        .block     (rd_block)
    );
`else
    assign rd_block = 1'b0;
`endif

    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_address     = '0;
        m_burstcount  = 3'd1;
        s_waitrequest = 1'b1;
        case (state)
            IDLE: begin
                if (s_read) begin
                    m_read       = ~rd_block;
                    m_address    = {s_address[ADDR_WIDTH-1:CCIP_AVMM_LINE_LSB], 6'b0};
                    m_burstcount = s_len;
                    // A burst that fits in one sub-burst completes with the downstream handshake.
                    if (BURST_WIDTH'(s_len) == s_burstcount) begin
                        s_waitrequest = m_waitrequest | rd_block;
                    end
                end else if (s_write) begin
                    m_write       = 1'b1;
                    m_address     = {s_address[ADDR_WIDTH-1:CCIP_AVMM_LINE_LSB], 6'b0};
                    m_burstcount  = s_len;
                    s_waitrequest = m_waitrequest;
                end else begin
                    s_waitrequest = m_waitrequest;
                end
            end
            RD_SPLIT: begin
                m_read        = ~rd_block;
                m_address     = {s_address[CCIP_AVMM_FENCE_BIT], cur_line, 6'b0};
                m_burstcount  = c_len;
                s_waitrequest = ~(~rd_block & ~m_waitrequest & (BURST_WIDTH'(c_len) == rem_total));
            end
            WR_BURST: begin
                m_write       = s_write;
                s_waitrequest = m_waitrequest;
                if (sub_left == 3'd0) begin
                    m_address    = {1'b0, cur_line, 6'b0};
                    m_burstcount = c_len;
                end else begin
                    m_address    = {fence_q & first_sub, sub_line, 6'b0};
                    m_burstcount = sub_len;
                end
            end
            default: begin
                s_waitrequest = 1'b1;
            end
        endcase
        if (reset) begin
            m_read        = 1'b0;
            m_write       = 1'b0;
            s_waitrequest = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_line  <= '0;
            sub_line  <= '0;
            rem_total <= '0;
            sub_left  <= '0;
            sub_len   <= '0;
            first_sub <= 1'b0;
            fence_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_read && !m_waitrequest && BURST_WIDTH'(s_len) != s_burstcount) begin
                        cur_line  <= s_line + LW'(s_len);
                        rem_total <= s_burstcount - BURST_WIDTH'(s_len);
                        state     <= RD_SPLIT;
                    end else if (m_write && !m_waitrequest && s_burstcount != BURST_WIDTH'(1)) begin
                        sub_line  <= s_line;
                        sub_len   <= s_len;
                        sub_left  <= s_len - 3'd1;
                        cur_line  <= s_line + LW'(s_len);
                        rem_total <= s_burstcount - BURST_WIDTH'(1);
                        first_sub <= 1'b1;
                        fence_q   <= s_address[CCIP_AVMM_FENCE_BIT];
                        state     <= WR_BURST;
                    end
                end
                RD_SPLIT: begin
                    if (accept) begin
                        cur_line  <= cur_line + LW'(c_len);
                        rem_total <= rem_total - BURST_WIDTH'(c_len);
                        if (BURST_WIDTH'(c_len) == rem_total) begin
                            state <= IDLE;
                        end
                    end
                end
                WR_BURST: begin
                    if (accept) begin
                        rem_total <= rem_total - BURST_WIDTH'(1);
                        if (sub_left == 3'd0) begin
                            sub_line  <= cur_line;
                            sub_len   <= c_len;
                            sub_left  <= c_len - 3'd1;
                            cur_line  <= cur_line + LW'(c_len);
                            first_sub <= 1'b0;
                        end else begin
                            sub_left <= sub_left - 3'd1;
                        end
                        if (rem_total == BURST_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_ccip_burst_splitter.sv
// tb/tb_avmm_ccip_burst_splitter.sv - scoreboard bench for avmm_ccip_burst_splitter
module tb_avmm_ccip_burst_splitter;

`ifdef CCIP_AVMM_SPLITTER_RD_THROTTLE_EN
    localparam int PEND = 8;
`else
    localparam int PEND = 256;
`endif

    typedef struct {
        bit          wr;
        logic [48:0] addr;
        logic [2:0]  bc;
        logic [31:0] data;
    } cmd_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [48:0]  s_address = '0;
    logic [6:0]   s_burstcount = 7'd1;
    logic         s_read = 1'b0;
    logic         s_write = 1'b0;
    logic [511:0] s_writedata = '0;
    logic [63:0]  s_byteenable = 64'h0123_4567_89AB_CDEF;
    logic         s_waitrequest;
    logic [511:0] s_readdata;
    logic         s_readdatavalid;
    logic [48:0]  m_address;
    logic [2:0]   m_burstcount;
    logic         m_read;
    logic         m_write;
    logic [511:0] m_writedata;
    logic [63:0]  m_byteenable;
    logic         m_waitrequest = 1'b0;
    logic [511:0] m_readdata = '0;
    logic         m_readdatavalid = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    cmd_t sb[$];
    int   accepts = 0;
    int   lines_issued = 0;
    int   lines_sent = 0;
    int   rd_seen = 0;
    int   exp_rd_lines = 0;
    bit   hold_rsp = 1'b0;

    always #5 clk = ~clk;

    avmm_ccip_burst_splitter #(
        .ADDR_WIDTH  (49),
        .DATA_WIDTH  (512),
        .BURST_WIDTH (7),
        .MAX_PEND_RD (PEND)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_burstcount    (m_burstcount),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference split: largest aligned 4/2/1 that fits, fence only on the first write sub-burst.
    task automatic push_subs(input bit wr, input logic [48:0] addr, input int bc, input int base);
        logic [41:0] ln;
        int rem, len, k;
        bit first;
        ln = addr[47:6];
        rem = bc;
        first = 1'b1;
        k = 0;
        while (rem > 0) begin
            if (ln[1:0] == 2'b00 && rem >= 4) len = 4;
            else if (!ln[0] && rem >= 2) len = 2;
            else len = 1;
            if (wr) begin
                for (int j = 0; j < len; j++) begin
                    sb.push_back('{1'b1, {first ? addr[48] : 1'b0, ln, 6'b0}, 3'(len), 32'(base + k)});
                    k++;
                end
            end else begin
                sb.push_back('{1'b0, {addr[48], ln, 6'b0}, 3'(len), 32'd0});
                exp_rd_lines += len;
            end
            ln += 42'(len);
            rem -= len;
            first = 1'b0;
        end
    endtask

    task automatic wait_accept(input bit rnd, input string tag, output int cycles);
        bit done;
        done = 1'b0;
        cycles = 0;
        while (!done && cycles < 300) begin
            m_waitrequest = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            done = !s_waitrequest;
            @(posedge clk);
            #1;
            cycles++;
        end
        m_waitrequest = 1'b0;
        if (!done) check(tag, 64'd0, 64'd1);
    endtask

    task automatic drive_write(input logic [48:0] addr, input int bc, input int base,
                               input int stall_beat, input bit rnd);
        int n, acc0;
        push_subs(1'b1, addr, bc, base);
        acc0 = accepts;
        for (int b = 0; b < bc; b++) begin
            s_write      = 1'b1;
            s_address    = (b == 0) ? addr : ~addr;
            s_burstcount = (b == 0) ? 7'(bc) : 7'h55;
            s_writedata  = {16{32'(base + b)}};
            if (b == stall_beat) begin
                m_waitrequest = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_addr", m_address, sb[0].addr);
                    check("stall_bc", m_burstcount, sb[0].bc);
                    check("stall_data", m_writedata[31:0], sb[0].data);
                    check("stall_beats", accepts - acc0, b);
                    @(posedge clk);
                    #1;
                end
            end
            wait_accept(rnd, "wr_timeout", n);
        end
        s_write = 1'b0;
        check("wr_beats", accepts - acc0, bc);
    endtask

    task automatic drive_read(input logic [48:0] addr, input int bc, input bit rnd, output int cycles);
        push_subs(1'b0, addr, bc, 0);
        s_read       = 1'b1;
        s_address    = addr;
        s_burstcount = 7'(bc);
        wait_accept(rnd, "rd_timeout", cycles);
        s_read = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rd_seen < exp_rd_lines || sb.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_sb"}, 64'(sb.size()), 64'd0);
        check({tag, "_rd_lines"}, 64'(rd_seen), 64'(exp_rd_lines));
    endtask

    always @(negedge clk) begin
        cmd_t e;
        if (!reset && (m_read || m_write) && !m_waitrequest) begin
            accepts++;
            if (sb.size() == 0) begin
                check("sb_underflow", {m_write, m_address}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("cmd_wr", m_write, e.wr);
                check("cmd_addr", m_address, e.addr);
                check("cmd_bc", m_burstcount, e.bc);
                if (e.wr) begin
                    check("wr_data", m_writedata[31:0], e.data);
                    check("wr_be", m_byteenable, 64'h0123_4567_89AB_CDEF);
                end else begin
                    lines_issued += int'(m_burstcount);
                end
            end
        end
        if (s_readdatavalid) begin
            check("rd_data", s_readdata[31:0], 32'(rd_seen));
            rd_seen++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!hold_rsp && lines_issued > lines_sent && $urandom_range(0, 1) == 1) begin
            m_readdatavalid = 1'b1;
            m_readdata      = {16{32'(lines_sent)}};
            lines_sent++;
        end else begin
            m_readdatavalid = 1'b0;
        end
    end

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check("rst_swait", s_waitrequest, 1'b1);
        check("rst_mread", m_read, 1'b0);
        check("rst_mwrite", m_write, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd", {m_read, m_write}, 2'b00);
        @(posedge clk);
        #1;

        drive_write({1'b0, 42'd1, 6'd0}, 7, 100, -1, 1'b1);
        drain("t1");

        drive_read({1'b0, 42'd0, 6'd0}, 64, 1'b0, cyc);
        check("rd64_cycles", 64'(cyc), 64'd16);
        drain("t2");

        drive_write({1'b1, 42'd2, 6'h15}, 4, 200, -1, 1'b0);
        drain("t3");

        drive_write({1'b0, 42'd8, 6'd0}, 4, 300, 2, 1'b0);
        drain("t4");

        drive_read({1'b0, 42'd1, 6'd0}, 3, 1'b1, cyc);
        drive_read({1'b1, 42'd7, 6'd0}, 1, 1'b1, cyc);
        drive_read({1'b0, 42'd6, 6'd0}, 9, 1'b1, cyc);
        drain("rdmix");

        drive_write({1'b1, 42'd3, 6'd0}, 1, 400, -1, 1'b0);
        drive_write({1'b0, 42'd13, 6'd0}, 64, 500, -1, 1'b1);
        drain("wrmix");

        // Reset lands on beat 2 of a 4-beat write; the rest of the burst is abandoned.
        push_subs(1'b1, {1'b0, 42'd0, 6'd0}, 4, 600);
        s_write = 1'b1; s_address = '0; s_burstcount = 7'd4; s_writedata = {16{32'd600}};
        wait_accept(1'b0, "rst_b1_timeout", cyc);
        s_writedata = {16{32'd601}};
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_mwrite", m_write, 1'b0);
        check("rst_mid_swait", s_waitrequest, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_write = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_idle", {m_read, m_write}, 2'b00);
        @(posedge clk);
        #1;
        drive_write({1'b0, 42'd5, 6'd0}, 3, 700, -1, 1'b0);
        drain("t6");

`ifdef CCIP_AVMM_SPLITTER_RD_THROTTLE_EN
        hold_rsp = 1'b1;
        drive_read({1'b0, 42'd0, 6'd0}, 4, 1'b0, cyc);
        drive_read({1'b0, 42'd4, 6'd0}, 4, 1'b0, cyc);
        push_subs(1'b0, {1'b0, 42'd8, 6'd0}, 4, 0);
        s_read = 1'b1; s_address = {1'b0, 42'd8, 6'd0}; s_burstcount = 7'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("thr_mread", m_read, 1'b0);
            check("thr_swait", s_waitrequest, 1'b1);
            @(posedge clk);
            #1;
        end
        hold_rsp = 1'b0;
        wait_accept(1'b0, "thr_timeout", cyc);
        s_read = 1'b0;
        drain("t5");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
